// File: rtl/mult_4bit_pkg.sv
// mult_4bit_pkg: shared operand and product widths for the array multiplier
package mult_4bit_pkg;
  localparam int OP_W = 4;
  localparam int PROD_W = 2 * OP_W;
endpackage

// File: rtl/mult_4bit_fa.sv
// mult_4bit_fa: 1-bit full adder cell (a, b, cin -> sum, cout)
module mult_4bit_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/mult_4bit.sv
// mult_4bit: combinational unsigned shift-and-add array multiplier, P = X*Y gated to 0 while rst is low
module mult_4bit
  import mult_4bit_pkg::*;
#(
  parameter int N = OP_W
) (
  input  logic         rst,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic [2*N-1:0] P
);
  logic [OP_W-1:0] pp [OP_W];
  logic [OP_W:0] acc [OP_W];
  logic [PROD_W-1:0] arr;
  for (genvar i = 0; i < OP_W; i++) begin : g_pp
    for (genvar j = 0; j < OP_W; j++) begin : g_bit
      assign pp[i][j] = X[j] & Y[i];
    end
  end
  assign acc[0] = {1'b0, pp[0]};
  // Each row adds the next partial product to the previous row shifted right by one;
  // the bit shifted out is final and drops straight into the product.
  for (genvar i = 1; i < OP_W; i++) begin : g_row
    logic [OP_W:0] c;
    assign c[0] = 1'b0;
    for (genvar j = 0; j < OP_W; j++) begin : g_fa
      mult_4bit_fa fa (
        .a(acc[i-1][j+1]),
        .b(pp[i][j]),
        .cin(c[j]),
        .sum(acc[i][j]),
        .cout(c[j+1])
      );
    end
    assign acc[i][OP_W] = c[OP_W];
  end
  for (genvar i = 0; i < OP_W; i++) begin : g_lo
    assign arr[i] = acc[i][0];
  end
  assign arr[PROD_W-1:OP_W] = acc[OP_W-1][OP_W:1];
  assign P = arr & {PROD_W{rst}};
endmodule

// File: tb/tb_mult_4bit.sv
// tb_mult_4bit: scoreboard bench for the combinational 4-bit array multiplier
module tb_mult_4bit;
  logic rst;
  logic [3:0] X;
  logic [3:0] Y;
  logic [7:0] P;
  logic [7:0] exp_q [$];
  string name_q [$];
  int tests = 0;
  int fails = 0;
  event presented;

  mult_4bit #(.N(4)) dut (.rst(rst), .X(X), .Y(Y), .P(P));

  task automatic apply(input logic r, input logic [3:0] x, input logic [3:0] y,
                       input logic [7:0] e, input string n, input int hold);
    rst = r;
    X = x;
    Y = y;
    exp_q.push_back(e);
    name_q.push_back(n);
    ->presented;
    #(hold);
  endtask

  initial begin : monitor
    logic [7:0] e;
    string n;
    forever begin
      @(presented);
      #1;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if (P !== e) begin
        fails++;
        $display("FAIL %s: rst=%0b X=%0d Y=%0d got P=%h expected %h", n, rst, X, Y, P, e);
      end
    end
  end

  initial begin : stimulus
    rst = 1'b0;
    X = 4'd0;
    Y = 4'd0;
    #2;
    apply(1'b0, 4'd0, 4'd0, 8'h00, "reset_state", 10);
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        apply(1'b1, 4'(x), 4'(y), 8'(x * y), "sweep", 10);
    apply(1'b1, 4'd15, 4'd15, 8'hE1, "max_225", 10);
    apply(1'b1, 4'd9, 4'd7, 8'd63, "9x7", 10);
    apply(1'b1, 4'd8, 4'd8, 8'd64, "8x8", 10);
    apply(1'b1, 4'd0, 4'd13, 8'd0, "0x13", 10);
    apply(1'b1, 4'd13, 4'd0, 8'd0, "13x0", 10);
    apply(1'b1, 4'd1, 4'd11, 8'd11, "1xY", 10);
    apply(1'b1, 4'd14, 4'd1, 8'd14, "Xx1", 10);
    apply(1'b0, 4'd15, 4'd15, 8'd0, "rst_low_15x15", 10);
    apply(1'b1, 4'd15, 4'd15, 8'd225, "rst_release", 10);
    apply(1'b1, 4'd12, 4'd5, 8'd60, "12x5", 10);
    apply(1'b0, 4'd12, 4'd5, 8'd0, "rst_pulse", 3);
    apply(1'b1, 4'd12, 4'd5, 8'd60, "after_pulse", 10);
    apply(1'b0, 4'd6, 4'd7, 8'd0, "rst_mid_change", 10);
    apply(1'b1, 4'd6, 4'd7, 8'd42, "release_new_ops", 10);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        apply(1'b1, 4'(1 << j), 4'(1 << i), 8'(1 << (i + j)), "walking_one", 10);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
